qtpa_hazard_ctrl: RTL
=====================

Name: qtpa_hazard_ctrl

Overview:
- Control-side partner of the ISS->EX pipeline register.
- Consumes the issue stage's register usage and the EX-stage source addresses captured by that register.
- Produces the stall and flush controls that drive the ISS->EX register, plus operand forwarding selects for EX.
- Holds a per-register pending scoreboard for load and multi-cycle multiply results, and a busy counter for the single non-pipelined multiplier.

Parameters:
- NUM_REGS, 16, architectural scalar registers (address width 4); register 0 is hardwired zero.
- MUL_LAT, 4, multiplier latency in cycles, legal range 2..15.
- LOAD_STALL, 1, extra cycles before a load result is forwardable, legal range 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- iss_valid  in  1  instruction present in ISSUE
- iss_rs1_addr  in  4  source 1 address
- iss_rs1_used  in  1  source 1 is read
- iss_rs2_addr  in  4  source 2 address
- iss_rs2_used  in  1  source 2 is read
- iss_rd_addr  in  4  destination address
- iss_we  in  1  instruction writes rd
- iss_is_mul  in  1  instruction uses the multiplier
- iss_is_load  in  1  instruction is a load
- redirect  in  1  branch/exception redirect resolved in EX
- ex_rs1_addr  in  4  EX source 1 address (from ISS->EX register)
- ex_rs2_addr  in  4  EX source 2 address (from ISS->EX register)
- mem_rd_addr  in  4  MEM stage destination
- mem_we  in  1  MEM stage writes
- wb_rd_addr  in  4  WB stage destination
- wb_we  in  1  WB stage writes
- stall  out  1  hold ISS->EX register and upstream
- flush  out  1  bubble ISS->EX register
- fwd_rs1_sel  out  2  EX operand 1 source
- fwd_rs2_sel  out  2  EX operand 2 source
- mul_busy  out  1  multiplier occupied

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. Reset clears every scoreboard counter and the multiplier busy counter to 0.
- Outputs during reset: all outputs are forced to 0 while rst is high (stall=0, flush=0, fwd selects=2'b00, mul_busy=0).
- Scoreboard: cnt[r] per register, width 4, where 0 means not pending. cnt[0] is always 0.
- Issue event: issue = iss_valid & ~stall & ~flush.
  - If issue & iss_we & (rd!=0): cnt[rd] is set to MUL_LAT-1 when iss_is_mul, LOAD_STALL when iss_is_load, and 0 otherwise.
  - iss_is_mul and iss_is_load together is illegal; mul takes precedence.
- Decrement: every other nonzero cnt decrements by 1 each cycle, regardless of stall. When the issue write and a decrement hit the same register in the same cycle, the issue write wins.
- Multiplier busy counter: on issue & iss_is_mul, busy <= MUL_LAT-1; otherwise it decrements while nonzero. mul_busy = (busy!=0).
- Hazard terms (combinational):
  - RAW: rsN_used & cnt[rsN]!=0.
  - WAW: iss_we & cnt[rd]!=0.
  - Structural: iss_is_mul & busy!=0.
  - hazard = iss_valid & (RAW1 | RAW2 | WAW | structural).
- ALU producers never cause a stall; their results are covered by forwarding.
- Control outputs:
  - flush = redirect.
  - stall = hazard & ~redirect, so flush has priority over stall.
  - Both are combinational, with zero latency from their inputs.
- Redirect does not clear the scoreboard: older in-flight mul/load results still retire. The flushed ISSUE instruction never updates the scoreboard.
- Forwarding, fwd_rsN_sel:
  - 2'b01 if mem_we & mem_rd==ex_rsN & ex_rsN!=0.
  - Otherwise 2'b10 if wb_we & wb_rd==ex_rsN & ex_rsN!=0.
  - Otherwise 2'b00.
  - MEM takes priority over WB. The encoding 2'b11 is never produced.
- Reset in mid-operation: all pending counters are discarded, and stall deasserts in the cycle after rst falls.

Decomposition:
- qtpa_pkg gains:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - MUL_LAT_DEFAULT and LOAD_STALL_DEFAULT constants.
  - REG_ADDR_W=4.
- One sub-module: qtpa_scoreboard, holding the cnt array with its set/decrement logic and per-address pending lookup ports. Forwarding and stall/flush combine in the top level.

Test Plan:
- Load-use, LOAD_STALL=1: issue load to r3, next cycle issue add reading r3 -> stall=1 for exactly 1 cycle, then the add issues; fwd_rs1_sel=FWD_WB when the add reaches EX.
- Mul-dependency, MUL_LAT=4: issue mul to r5, dependent reads r5 -> stall held 3 cycles; mul_busy=1 for 3 cycles after issue.
- Back-to-back muls to r6 and r7 (independent) -> second mul stalls 3 cycles on the structural hazard, then issues; r7 pending afterward.
- Redirect during mul-induced stall -> flush=1, stall=0 that cycle; cnt[r5] continues counting down and a later reader of r5 still stalls for the remaining cycles.
- Forwarding priority: ex_rs1=r2, mem_rd=r2/mem_we=1, wb_rd=r2/wb_we=1 -> fwd_rs1_sel=01. With ex_rs2=r0 and mem_rd=r0 -> fwd_rs2_sel=00.
- Reset asserted with cnt[r4]=2 pending -> after rst, a reader of r4 issues with stall=0; load to r0 -> no scoreboard entry and no stall for readers of r0.

Source files
------------

// File: rtl/qtpa_pkg.sv
// qtpa_pkg: shared types and defaults for the QTPA issue/execute hazard control.
// Provides the register address type, forwarding-select encoding and a helper
// that picks the forwarding source for one EX operand.
package qtpa_pkg;
    localparam int REG_ADDR_W         = 4;
    localparam int NUM_REGS_DEFAULT   = 16;
    localparam int MUL_LAT_DEFAULT    = 4;
    localparam int LOAD_STALL_DEFAULT = 1;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    // MEM is younger than WB, so it wins; r0 is never forwarded.
    function automatic fwd_sel_t fwd_pick(input reg_addr_t src, input reg_addr_t mem_rd,
                                          input logic mem_we, input reg_addr_t wb_rd,
                                          input logic wb_we);
        return (src == '0) ? FWD_RF :
               (mem_we && mem_rd == src) ? FWD_MEM :
               (wb_we && wb_rd == src) ? FWD_WB : FWD_RF;
    endfunction
endpackage

// File: rtl/qtpa_hazard_ctrl_if.sv
// qtpa_hazard_ctrl_if: pipeline <-> hazard control signal bundle.
// master: pipeline side (drives issue/EX/MEM/WB info, receives controls).
// slave:  hazard control side (receives pipeline info, drives stall/flush/fwd/mul_busy).
interface qtpa_hazard_ctrl_if;
    import qtpa_pkg::*;
    logic      iss_valid;
    reg_addr_t iss_rs1_addr;
    logic      iss_rs1_used;
    reg_addr_t iss_rs2_addr;
    logic      iss_rs2_used;
    reg_addr_t iss_rd_addr;
    logic      iss_we;
    logic      iss_is_mul;
    logic      iss_is_load;
    logic      redirect;
    reg_addr_t ex_rs1_addr;
    reg_addr_t ex_rs2_addr;
    reg_addr_t mem_rd_addr;
    logic      mem_we;
    reg_addr_t wb_rd_addr;
    logic      wb_we;
    logic      stall;
    logic      flush;
    fwd_sel_t  fwd_rs1_sel;
    fwd_sel_t  fwd_rs2_sel;
    logic      mul_busy;

    modport master (
        output iss_valid, iss_rs1_addr, iss_rs1_used, iss_rs2_addr, iss_rs2_used,
               iss_rd_addr, iss_we, iss_is_mul, iss_is_load, redirect,
               ex_rs1_addr, ex_rs2_addr, mem_rd_addr, mem_we, wb_rd_addr, wb_we,
        input  stall, flush, fwd_rs1_sel, fwd_rs2_sel, mul_busy
    );

    modport slave (
        input  iss_valid, iss_rs1_addr, iss_rs1_used, iss_rs2_addr, iss_rs2_used,
               iss_rd_addr, iss_we, iss_is_mul, iss_is_load, redirect,
               ex_rs1_addr, ex_rs2_addr, mem_rd_addr, mem_we, wb_rd_addr, wb_we,
        output stall, flush, fwd_rs1_sel, fwd_rs2_sel, mul_busy
    );
endinterface

// File: rtl/qtpa_scoreboard.sv
// qtpa_scoreboard: per-register pending counters for load and multiply results.
// Ports: clk/rst; set_en/set_addr/set_mul/set_load load a counter on issue;
// rs1/rs2/rd_addr look up pending state, reported on rs1/rs2/rd_pend.
module qtpa_scoreboard
    import qtpa_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEFAULT,
    parameter int MUL_LAT    = MUL_LAT_DEFAULT,
    parameter int LOAD_STALL = LOAD_STALL_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  logic      set_mul,
    input  logic      set_load,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    input  reg_addr_t rd_addr,
    output logic      rs1_pend,
    output logic      rs2_pend,
    output logic      rd_pend
);
    localparam logic [3:0] MUL_INIT  = 4'(MUL_LAT - 1);
    localparam logic [3:0] LOAD_INIT = 4'(LOAD_STALL);

    logic [3:0] cnt [NUM_REGS];

    // A fresh issue write overrides the countdown of the same register;
    // an ALU producer writes 0 since forwarding covers it.
    always_ff @(posedge clk)
        for (int r = 0; r < NUM_REGS; r++)
            if (rst || r == 0) cnt[r] <= '0;
            else if (set_en && set_addr == reg_addr_t'(r))
                cnt[r] <= set_mul ? MUL_INIT : set_load ? LOAD_INIT : '0;
            else if (cnt[r] != '0) cnt[r] <= cnt[r] - 4'd1;

    always_comb begin
        rs1_pend = cnt[rs1_addr] != '0;
        rs2_pend = cnt[rs2_addr] != '0;
        rd_pend  = cnt[rd_addr] != '0;
    end
endmodule

// File: rtl/qtpa_hazard_ctrl.sv
// qtpa_hazard_ctrl: stall/flush and operand forwarding control for the ISS->EX register.
// Ports: clk, rst (sync, active-high); hc (slave modport) carries the issue
// stage usage, EX/MEM/WB addresses, redirect, and the stall, flush,
// fwd_rs1_sel, fwd_rs2_sel and mul_busy outputs.
module qtpa_hazard_ctrl
    import qtpa_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEFAULT,
    parameter int MUL_LAT    = MUL_LAT_DEFAULT,
    parameter int LOAD_STALL = LOAD_STALL_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    qtpa_hazard_ctrl_if.slave hc
);
    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

    logic [3:0] busy;
    logic       pend_rs1, pend_rs2, pend_rd, hazard, issue;

    qtpa_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .MUL_LAT   (MUL_LAT),
        .LOAD_STALL(LOAD_STALL)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue & hc.iss_we),
        .set_addr(hc.iss_rd_addr),
        .set_mul (hc.iss_is_mul),
        .set_load(hc.iss_is_load),
        .rs1_addr(hc.iss_rs1_addr),
        .rs2_addr(hc.iss_rs2_addr),
        .rd_addr (hc.iss_rd_addr),
        .rs1_pend(pend_rs1),
        .rs2_pend(pend_rs2),
        .rd_pend (pend_rd)
    );

    // Outputs are held at zero during reset; redirect outranks any stall.
    always_comb begin
        hazard = hc.iss_valid & ((hc.iss_rs1_used & pend_rs1) | (hc.iss_rs2_used & pend_rs2) |
                                 (hc.iss_we & pend_rd) | (hc.iss_is_mul & (busy != '0)));
        hc.flush       = ~rst & hc.redirect;
        hc.stall       = ~rst & hazard & ~hc.redirect;
        hc.mul_busy    = ~rst & (busy != '0);
        hc.fwd_rs1_sel = rst ? FWD_RF : fwd_pick(hc.ex_rs1_addr, hc.mem_rd_addr, hc.mem_we,
                                                 hc.wb_rd_addr, hc.wb_we);
        hc.fwd_rs2_sel = rst ? FWD_RF : fwd_pick(hc.ex_rs2_addr, hc.mem_rd_addr, hc.mem_we,
                                                 hc.wb_rd_addr, hc.wb_we);
        issue          = hc.iss_valid & ~hc.stall & ~hc.flush;
    end

    always_ff @(posedge clk)
        if (rst) busy <= '0;
        else if (issue & hc.iss_is_mul) busy <= MUL_INIT;
        else if (busy != '0) busy <= busy - 4'd1;
endmodule
